// File: rtl/debug_latch_serializer.sv
// Streams a captured pipeline-latch snapshot to the debug UART TX as one frame:
// HEADER, snapshot bytes LSB-first, then the XOR checksum of the snapshot bytes.
module debug_latch_serializer #(
    parameter int           NB_DATA = 85,
    parameter int           NB_BYTE = 8,
    parameter logic [7:0]   HEADER  = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_latch_data,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NB_BYTES = (NB_DATA + NB_BYTE - 1) / NB_BYTE;
    localparam int CNT_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NB_BYTE-1:0]   csum_q, csum_d;
    logic [NB_DATA-1:0]   snap_q, snap_d;

    logic [NB_BYTES*NB_BYTE-1:0]       snap_pad;
    logic [NB_BYTES-1:0][NB_BYTE-1:0]  bytes_w;
    logic [NB_BYTE-1:0]                cur_byte;
    logic                              accept;

    // Top byte is zero-padded above the snapshot MSB.
    always_comb begin
        snap_pad              = '0;
        snap_pad[NB_DATA-1:0] = snap_q;
    end

    assign bytes_w  = snap_pad;
    assign cur_byte = bytes_w[cnt_q];
    assign accept   = o_tx_valid && i_tx_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            csum_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        snap_d  = snap_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    snap_d  = i_latch_data;
                    cnt_d   = '0;
                    csum_d  = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) state_d = S_DATA;
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ cur_byte;
                    if (cnt_q == LAST_IDX) state_d = S_CSUM;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            S_CSUM: begin
                if (accept) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode registered state only; no path from i_tx_ready/i_start.
    always_comb begin
        o_tx_data  = '0;
        o_tx_valid = 1'b0;
        case (state_q)
            S_HDR: begin
                o_tx_data  = HEADER;
                o_tx_valid = 1'b1;
            end
            S_DATA: begin
                o_tx_data  = cur_byte;
                o_tx_valid = 1'b1;
            end
            S_CSUM: begin
                o_tx_data  = csum_q;
                o_tx_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_busy = (state_q != S_IDLE);
    assign o_done = (state_q == S_DONE);

endmodule

// File: tb/tb_debug_latch_serializer.sv
// Directed bench for debug_latch_serializer: frames with hand-computed bytes,
// backpressure, ignored starts, mid-frame reset and back-to-back frames.
module tb_debug_latch_serializer;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [84:0] i_latch_data;
    logic        i_tx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_busy;
    logic        o_done;

    int total = 0;
    int bad   = 0;

    debug_latch_serializer dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_latch_data (i_latch_data),
        .i_tx_ready   (i_tx_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Frames written header-first, one byte per pair of hex digits.
    localparam logic [103:0] FR_ONE  = 104'hA5_01_00_00_00_00_00_00_00_00_00_00_01;
    localparam logic [103:0] FR_ONES = 104'hA5_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_1F_1F;
    localparam logic [103:0] FR_SEQ  = 104'hA5_16_15_14_13_12_11_10_0F_0E_0D_0C_17;
    localparam logic [84:0]  D_ONE   = 85'h1;
    localparam logic [84:0]  D_SEQ   = 85'h0C_0D0E_0F10_1112_1314_1516;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge where the header should be on the bus.
    // stall = ready-low cycles before each accept; poke = start/data change
    // during byte 5 plus a start pulse in the DONE cycle.
    task automatic send_frame(input logic [103:0] expf, input int stall,
                              input bit poke, input string tag);
        logic [7:0] e;
        for (int i = 0; i < 13; i++) begin
            e = expf[8*(12-i) +: 8];
            for (int s = 0; s <= stall; s++) begin
                chk({tag, " valid"}, {31'd0, o_tx_valid}, 32'd1);
                chk({tag, " data"}, {24'd0, o_tx_data}, {24'd0, e});
                chk({tag, " busy"}, {31'd0, o_busy}, 32'd1);
                if (poke && i == 5 && s == 0) begin
                    i_start      = 1'b1;
                    i_latch_data = '1;
                end else if (poke) begin
                    i_start = 1'b0;
                end
                i_tx_ready = (s == stall);
                @(negedge i_clk);
            end
        end
        chk({tag, " done"}, {31'd0, o_done}, 32'd1);
        chk({tag, " done busy"}, {31'd0, o_busy}, 32'd1);
        chk({tag, " done valid"}, {31'd0, o_tx_valid}, 32'd0);
        if (poke) i_start = 1'b1;
        @(negedge i_clk);
        if (poke) i_start = 1'b0;
        chk({tag, " idle busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, " idle valid"}, {31'd0, o_tx_valid}, 32'd0);
        chk({tag, " idle done"}, {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_start      = 1'b0;
        i_latch_data = '0;
        i_tx_ready   = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("rst data", {24'd0, o_tx_data}, 32'd0);
        chk("rst valid", {31'd0, o_tx_valid}, 32'd0);
        chk("rst busy", {31'd0, o_busy}, 32'd0);
        chk("rst done", {31'd0, o_done}, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("post-rst valid", {31'd0, o_tx_valid}, 32'd0);

        // Ready always high, snapshot 1.
        i_latch_data = D_ONE;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        send_frame(FR_ONE, 0, 1'b0, "one");

        // All ones: padding in the top byte and checksum.
        i_latch_data = '1;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        send_frame(FR_ONES, 0, 1'b0, "ones");

        // Three stall cycles per byte; data must hold for four cycles.
        i_latch_data = D_SEQ;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        send_frame(FR_SEQ, 3, 1'b0, "stall");
        i_tx_ready = 1'b1;

        // Start + data change mid-frame and a start in DONE are both ignored.
        i_latch_data = D_ONE;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        send_frame(FR_ONE, 0, 1'b1, "poke");
        @(negedge i_clk);
        chk("poke still idle", {31'd0, o_busy}, 32'd0);

        // Reset after the 4th accepted byte aborts the frame immediately.
        i_latch_data = D_SEQ;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("pre-rst busy", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1;
        #1;
        chk("mid-rst data", {24'd0, o_tx_data}, 32'd0);
        chk("mid-rst valid", {31'd0, o_tx_valid}, 32'd0);
        chk("mid-rst busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("after-rst valid", {31'd0, o_tx_valid}, 32'd0);
        i_latch_data = '1;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        send_frame(FR_ONES, 1, 1'b0, "rerun");

        // Start held high: frames separated by one DONE and one IDLE cycle.
        i_latch_data = D_ONE;
        i_start      = 1'b1;
        @(negedge i_clk);
        send_frame(FR_ONE, 0, 1'b0, "b2b0");
        @(negedge i_clk);
        send_frame(FR_ONE, 0, 1'b0, "b2b1");
        i_start = 1'b0;
        @(negedge i_clk);
        chk("b2b end busy", {31'd0, o_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
